// File: rtl/flight_arming_controller.sv
// flight_arming_controller
// Safety gate between receiver decode and the motor path. Owns arm/disarm,
// watches for receiver loss and IMU failure, passes throttle only while
// armed, and ramps throttle to zero in FAILSAFE before disarming.
// Ports:
//   sys_clk, resetn (sync, active-low)
//   rx_update     : 1-cycle pulse per fresh receiver frame
//   imu_good      : IMU healthy level
//   throttle_val  : receiver throttle
//   aux1_val      : receiver arm switch channel
//   throttle_out  : gated throttle (registered)
//   armed         : high only in ARMED (registered)
//   failsafe      : high only in FAILSAFE (registered)
//   state         : DISARMED=0, ARMING=1, ARMED=2, FAILSAFE=3 (registered)
module flight_arming_controller #(
    parameter int unsigned CLK_PER_MS      = 38000,
    parameter int unsigned ARM_HOLD_MS     = 1000,
    parameter int unsigned RX_TIMEOUT_MS   = 100,
    parameter int unsigned DESCENT_STEP_MS = 20,
    parameter logic [7:0]  THR_ARM_MAX     = 8'd10,
    parameter logic [7:0]  ARM_SW_THRESH   = 8'd200
) (
    input  logic       sys_clk,
    input  logic       resetn,
    input  logic       rx_update,
    input  logic       imu_good,
    input  logic [7:0] throttle_val,
    input  logic [7:0] aux1_val,
    output logic [7:0] throttle_out,
    output logic       armed,
    output logic       failsafe,
    output logic [1:0] state
);

    localparam int unsigned MS_W   = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int unsigned HOLD_W = $clog2(ARM_HOLD_MS + 1);
    localparam int unsigned AGE_W  = $clog2(RX_TIMEOUT_MS + 1);
    localparam int unsigned STEP_W = $clog2(DESCENT_STEP_MS + 1);

    typedef enum logic [1:0] {
        S_DISARMED = 2'd0,
        S_ARMING   = 2'd1,
        S_ARMED    = 2'd2,
        S_FAILSAFE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [MS_W-1:0]     r_ms_cnt;
    logic [AGE_W-1:0]    r_rx_age;
    logic [HOLD_W-1:0]   r_hold;
    logic [HOLD_W-1:0]   w_hold_nxt;
    logic [STEP_W-1:0]   r_step;
    logic [STEP_W-1:0]   w_step_nxt;
    logic [7:0]          r_thr;
    logic [7:0]          w_thr_nxt;
    logic                r_sw_rel;
    logic                w_sw_rel_nxt;
    logic                r_armed;
    logic                r_failsafe;

    logic w_ms_tick;
    logic w_rx_lost;
    logic w_arm_sw;
    logic w_ok;
    logic w_arm_cond;

    assign w_ms_tick  = (r_ms_cnt == MS_W'(CLK_PER_MS - 1));
    assign w_rx_lost  = (r_rx_age == AGE_W'(RX_TIMEOUT_MS));
    assign w_arm_sw   = (aux1_val >= ARM_SW_THRESH);
    assign w_ok       = imu_good & ~w_rx_lost;
    assign w_arm_cond = w_arm_sw & w_ok & (throttle_val <= THR_ARM_MAX);

    // Free-running ms prescaler, untouched by state changes
    always_ff @(posedge sys_clk) begin
        if (!resetn)        r_ms_cnt <= '0;
        else if (w_ms_tick) r_ms_cnt <= '0;
        else                r_ms_cnt <= r_ms_cnt + MS_W'(1);
    end

    // Receiver watchdog; a frame clear beats a coincident tick, reset reads as lost
    always_ff @(posedge sys_clk) begin
        if (!resetn)                       r_rx_age <= AGE_W'(RX_TIMEOUT_MS);
        else if (rx_update)                r_rx_age <= '0;
        else if (w_ms_tick && !w_rx_lost)  r_rx_age <= r_rx_age + AGE_W'(1);
    end

    // State register
    always_ff @(posedge sys_clk) begin
        if (!resetn) r_state <= S_DISARMED;
        else         r_state <= w_state_nxt;
    end

    // Next-state and datapath next values
    always_comb begin
        w_state_nxt  = r_state;
        w_thr_nxt    = r_thr;
        w_hold_nxt   = r_hold;
        w_step_nxt   = r_step;
        w_sw_rel_nxt = r_sw_rel;

        case (r_state)
            S_DISARMED: begin
                w_thr_nxt = 8'd0;
                if (!w_arm_sw) w_sw_rel_nxt = 1'b1;
                if (w_arm_cond && r_sw_rel) begin
                    w_state_nxt = S_ARMING;
                    w_hold_nxt  = '0;
                end
            end
            S_ARMING: begin
                w_thr_nxt = 8'd0;
                if (!w_arm_cond)                          w_state_nxt = S_DISARMED;
                else if (r_hold == HOLD_W'(ARM_HOLD_MS))  w_state_nxt = S_ARMED;
                else if (w_ms_tick)                       w_hold_nxt  = r_hold + HOLD_W'(1);
            end
            S_ARMED: begin
                w_thr_nxt = throttle_val;
                // Loss of health wins over the switch; hold last throttle for the ramp
                if (!w_ok) begin
                    w_state_nxt = S_FAILSAFE;
                    w_thr_nxt   = r_thr;
                    w_step_nxt  = '0;
                end else if (!w_arm_sw) begin
                    w_state_nxt = S_DISARMED;
                    w_thr_nxt   = 8'd0;
                end
            end
            S_FAILSAFE: begin
                if (r_thr == 8'd0) begin
                    w_state_nxt = S_DISARMED;
                end else if (r_step == STEP_W'(DESCENT_STEP_MS)) begin
                    w_step_nxt = '0;
                    w_thr_nxt  = r_thr - 8'd1;
                end else if (w_ms_tick) begin
                    w_step_nxt = r_step + STEP_W'(1);
                end
            end
            default: w_state_nxt = S_DISARMED;
        endcase

        // Every entry to DISARMED demands a fresh switch-off before re-arming
        if (w_state_nxt == S_DISARMED && r_state != S_DISARMED) w_sw_rel_nxt = 1'b0;
    end

    // Datapath and registered status outputs
    always_ff @(posedge sys_clk) begin
        if (!resetn) begin
            r_thr      <= 8'd0;
            r_hold     <= '0;
            r_step     <= '0;
            r_sw_rel   <= 1'b0;
            r_armed    <= 1'b0;
            r_failsafe <= 1'b0;
        end else begin
            r_thr      <= w_thr_nxt;
            r_hold     <= w_hold_nxt;
            r_step     <= w_step_nxt;
            r_sw_rel   <= w_sw_rel_nxt;
            r_armed    <= (w_state_nxt == S_ARMED);
            r_failsafe <= (w_state_nxt == S_FAILSAFE);
        end
    end

    assign throttle_out = r_thr;
    assign armed        = r_armed;
    assign failsafe     = r_failsafe;
    assign state        = r_state;

endmodule

// File: tb/tb_flight_arming_controller.sv
// Directed bench for flight_arming_controller with a cycle-tagged scoreboard.
module tb_flight_arming_controller;

    logic       sys_clk = 1'b0;
    logic       resetn;
    logic       rx_update;
    logic       imu_good;
    logic [7:0] throttle_val;
    logic [7:0] aux1_val;
    logic [7:0] throttle_out;
    logic       armed;
    logic       failsafe;
    logic [1:0] state;

    flight_arming_controller #(
        .CLK_PER_MS(4), .ARM_HOLD_MS(5), .RX_TIMEOUT_MS(3), .DESCENT_STEP_MS(2)
    ) dut (
        .sys_clk(sys_clk), .resetn(resetn), .rx_update(rx_update),
        .imu_good(imu_good), .throttle_val(throttle_val), .aux1_val(aux1_val),
        .throttle_out(throttle_out), .armed(armed), .failsafe(failsafe), .state(state)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int    cyc;
        string name;
        int    st, thr, arm, fs, age, lost;   // -1 = don't care
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   ph     = 0;
    int   ntick  = 0;
    bit   rx_en  = 1'b1;

    // Cycle count and ms-tick phase as seen by the DUT at each edge
    always @(posedge sys_clk) begin
        cyc++;
        if (!resetn) ph = 0;
        else if (ph == 3) begin ph = 0; ntick++; end
        else ph++;
    end

    // Background receiver frames every 8 cycles
    always @(negedge sys_clk) if (rx_en) rx_update = (cyc % 8 == 0);

    function automatic bit bad(int want, int got);
        return (want >= 0) && (want != got);
    endfunction

    // Monitor: compare outputs against entries tagged for this cycle
    always @(negedge sys_clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            int ast, athr, aarm, afs, aage, alost;
            e = q.pop_front();
            checks++;
            ast = int'(state); athr = int'(throttle_out); aarm = int'(armed);
            afs = int'(failsafe); aage = int'(dut.r_rx_age); alost = int'(dut.w_rx_lost);
            if (e.cyc < cyc) begin
                errors++;
                $display("FAIL %s: stale entry for cycle %0d at cycle %0d", e.name, e.cyc, cyc);
            end else if (bad(e.st, ast) || bad(e.thr, athr) || bad(e.arm, aarm) ||
                         bad(e.fs, afs) || bad(e.age, aage) || bad(e.lost, alost)) begin
                errors++;
                $display("FAIL %s @%0d: got st=%0d thr=%0d arm=%0d fs=%0d age=%0d lost=%0d want st=%0d thr=%0d arm=%0d fs=%0d age=%0d lost=%0d",
                         e.name, cyc, ast, athr, aarm, afs, aage, alost,
                         e.st, e.thr, e.arm, e.fs, e.age, e.lost);
            end
        end
    end

    task automatic expect_at(string nm, int d, int st, int thr, int arm, int fs,
                             int age = -1, int lost = -1);
        exp_t e;
        e.cyc = cyc + d; e.name = nm; e.st = st; e.thr = thr;
        e.arm = arm; e.fs = fs; e.age = age; e.lost = lost;
        q.push_back(e);
    endtask

    task automatic step(int n);
        repeat (n) begin @(posedge sys_clk); #1; end
    endtask

    task automatic wait_ticks(int n);
        int n0 = ntick;
        int g  = 0;
        while (ntick < n0 + n && g < 1000) begin step(1); g++; end
    endtask

    // Switch-off cycle, then arm at throttle v and hold through ARMING
    task automatic do_arm(int v);
        aux1_val = 8'd0;
        step(2);
        aux1_val = 8'd255; throttle_val = 8'(v);
        expect_at("arming_entry", 1, 1, 0, 0, 0);
        step(1);
        wait_ticks(5);
        expect_at("arming_hold", 0, 1, 0, 0, 0);
        expect_at("armed_entry", 1, 2, -1, 1, 0);
        expect_at("armed_thr", 2, 2, v, 1, 0);
        step(2);
    endtask

    // Stop frames after one last clear; returns on the edge rx_lost asserts
    task automatic lose_rx();
        rx_en = 1'b0; rx_update = 1'b1;
        step(1);
        rx_update = 1'b0;
        wait_ticks(3);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        resetn = 1'b0; rx_update = 1'b0; imu_good = 1'b1;
        throttle_val = 8'd0; aux1_val = 8'd0;
        step(3);
        expect_at("reset", 0, 0, 0, 0, 0, 3, 1);

        // Switch high straight out of reset never arms
        resetn = 1'b1; aux1_val = 8'd255;
        step(20);
        expect_at("sw_high_from_reset", 0, 0, 0, 0, 0);

        // Arm, then pass throttle with one cycle latency
        do_arm(5);
        throttle_val = 8'd120;
        expect_at("thr_pass_120", 1, 2, 120, 1, 0);
        step(1);
        throttle_val = 8'd77;
        expect_at("thr_pass_77", 1, 2, 77, 1, 0);
        step(1);
        aux1_val = 8'd0;
        expect_at("switch_disarm", 1, 0, 0, 0, 0);
        step(3);

        // Throttle above arm limit blocks arming
        throttle_val = 8'd50; aux1_val = 8'd255;
        expect_at("thr_high", 1, 0, 0, 0, 0);
        expect_at("thr_high_hold", 6, 0, 0, 0, 0);
        step(8);

        // Switch drops partway through ARMING
        throttle_val = 8'd5; aux1_val = 8'd0;
        step(2);
        aux1_val = 8'd255;
        expect_at("arming_again", 1, 1, 0, 0, 0);
        step(1);
        wait_ticks(3);
        expect_at("arming_3ms", 0, 1, 0, 0, 0);
        aux1_val = 8'd0;
        expect_at("arm_abort", 1, 0, 0, 0, 0);
        expect_at("arm_abort_noarm", 3, 0, 0, 0, 0);
        step(4);

        // Receiver loss: ramp 6 -> 0, 2 ms per step, restoring frames does not abort
        do_arm(6);
        lose_rx();
        expect_at("rx_lost_still_armed", 0, 2, 6, 1, 0, 3, 1);
        expect_at("failsafe_entry", 1, 3, 6, 0, 1);
        expect_at("failsafe_hold6", 8, 3, 6, 0, 1);
        for (int k = 1; k <= 6; k++) expect_at("descent_step", 1 + 8 * k, 3, 6 - k, 0, 1);
        expect_at("descent_disarm", 50, 0, 0, 0, 0);
        step(3);
        rx_en = 1'b1;
        step(47);
        expect_at("no_rearm_switch_on", 10, 0, 0, 0, 0);
        step(12);

        // IMU failure together with switch-off goes to FAILSAFE
        do_arm(10);
        imu_good = 1'b0; aux1_val = 8'd0;
        expect_at("imu_fail_failsafe", 1, 3, 10, 0, 1);
        step(2);
        imu_good = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (state == 2'd0) break;
            step(1);
        end
        expect_at("imu_descent_done", 0, 0, 0, 0, 0);
        step(2);

        // Watchdog: frame clear coinciding with a tick at age 2
        rx_en = 1'b0; rx_update = 1'b1;
        step(1);
        rx_update = 1'b0;
        wait_ticks(2);
        expect_at("age_two", 0, 0, 0, 0, 0, 2, 0);
        step(3);
        rx_update = 1'b1;
        step(1);
        rx_update = 1'b0;
        expect_at("tick_clear_wins", 0, 0, 0, 0, 0, 0, 0);
        wait_ticks(2);
        expect_at("age_after_clear", 0, 0, 0, 0, 0, 2, 0);
        rx_en = 1'b1;
        step(16);

        // Reset in the middle of a FAILSAFE descent
        do_arm(6);
        lose_rx();
        step(18);
        expect_at("fs_thr4", 0, 3, 4, 0, 1);
        resetn = 1'b0;
        expect_at("reset_mid_fs", 1, 0, 0, 0, 0, 3, 1);
        step(1);
        resetn = 1'b1; rx_en = 1'b1;
        step(5);
        expect_at("post_reset", 0, 0, 0, 0, 0);
        step(3);

        if (q.size() != 0) begin
            $display("FAIL pending: %0d expectations never compared", q.size());
            checks += q.size();
            errors += q.size();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
